multi_updown_counter: RTL and testbench
=======================================

// Module: multi_updown_counter
// PURPOSE
//  Parametrised bank of NUM_CH independent up/down counters sharing one clock and reset.
//  Per channel: enable, direction, saturate-or-wrap mode, synchronous clear and parallel load.
//  Boundary flags and wrap pulses go to downstream control logic.
//  Next-generation replacement for the fixed dual 16/32-bit saturating up/down counter pair.
// PARAMETERS
//  NUM_CH   4                 number of independent counter channels (>=1)
//  WIDTH    16                bits per counter (>=2)
//  MAX_VAL  (2**WIDTH)-1      upper count limit, same for all channels; lower limit is 0
// PORTS
//  CLK       in   1               system clock, rising-edge active
//  RST       in   1               asynchronous, active-high reset for all channels
//  EN        in   NUM_CH          per-channel count enable
//  UP_DWN    in   NUM_CH          per-channel direction: 1 = up, 0 = down
//  SAT_MODE  in   NUM_CH          per-channel mode: 1 = saturate at limits, 0 = wrap
//  CLR       in   NUM_CH          per-channel synchronous clear to 0
//  LOAD      in   NUM_CH          per-channel synchronous load of LOAD_VAL slice
//  LOAD_VAL  in   NUM_CH*WIDTH    load values; channel i uses bits [i*WIDTH +: WIDTH]
//  COUNT     out  NUM_CH*WIDTH    registered counts; channel i in [i*WIDTH +: WIDTH]
//  AT_MAX    out  NUM_CH          1 when channel COUNT == MAX_VAL (combinational from register)
//  AT_MIN    out  NUM_CH          1 when channel COUNT == 0 (combinational from register)
//  WRAP      out  NUM_CH          registered 1-cycle pulse; channel wrapped on the previous edge
// BEHAVIOUR
//  - Reset: RST=1 forces all COUNT = 0 and WRAP = 0 immediately, without waiting for a clock edge.
//    Flags follow: AT_MIN = all 1s; AT_MAX = 0.
//    Reset asserted mid-count aborts that channel's operation.
//    The first edge after RST falls evaluates normally.
//  - Per-channel priority on each rising CLK edge: CLR > LOAD > EN count > hold.
//  - CLR=1: COUNT <= 0, WRAP <= 0.
//  - LOAD=1: COUNT <= min(LOAD_VAL slice, MAX_VAL), WRAP <= 0. Out-of-range loads clamp to MAX_VAL.
//  - EN=1, UP_DWN=1, COUNT < MAX_VAL: COUNT <= COUNT+1.
//  - EN=1, UP_DWN=0, COUNT > 0: COUNT <= COUNT-1.
//  - Upper limit, EN=1, UP_DWN=1, COUNT == MAX_VAL:
//      SAT_MODE=1: hold MAX_VAL, WRAP <= 0.
//      SAT_MODE=0: COUNT <= 0, WRAP <= 1.
//  - Lower limit, EN=1, UP_DWN=0, COUNT == 0:
//      SAT_MODE=1: hold 0, WRAP <= 0.
//      SAT_MODE=0: COUNT <= MAX_VAL, WRAP <= 1.
//  - EN=0, no CLR or LOAD: COUNT holds, WRAP <= 0.
//  - WRAP is high for exactly 1 cycle per wrap event, coincident with the wrapped COUNT value.
//  - Latency: COUNT updates 1 cycle after inputs are sampled. AT_MAX and AT_MIN add no latency.
//  - UP_DWN and SAT_MODE may change on any cycle; each takes effect on the next edge.
//    There is no hidden state beyond COUNT and WRAP.
//  - Arithmetic is unsigned, WIDTH bits.
//    When MAX_VAL < 2**WIDTH-1, counts never exceed MAX_VAL; the wrap target is MAX_VAL, not 2**WIDTH-1.
//  - Channels are fully independent; simultaneous events on different channels never interact.
// TESTING  (bench: NUM_CH=2, WIDTH=4, MAX_VAL=15 unless stated)
//  1. RST=1 at t=0, release after 15ns, EN=11, UP_DWN=11, SAT_MODE=11, 20 edges
//     -> both COUNT go 1..15 then hold 15; AT_MAX=11 from edge 15; WRAP stays 0.
//  2. Ch0 SAT_MODE=0, UP_DWN=1, from 14, 3 edges -> 15, 0, 1; WRAP[0] high only on the cycle COUNT=0.
//     Then UP_DWN=0 from 0 -> 15 with WRAP[0] pulse.
//  3. Ch1 LOAD=1, LOAD_VAL=9, CLR=1 same edge -> COUNT1=0.
//     LOAD alone with EN=1 -> COUNT1=9 (load beats count).
//  4. MAX_VAL=10: LOAD_VAL=13 -> COUNT=10, AT_MAX=1.
//     Wrap mode counting up from 10 -> 0 with WRAP pulse.
//  5. Count at 7, assert RST mid-cycle (between edges) -> COUNT=0 before the next edge.
//     Release -> counting resumes from 0 on the next edge.
//  6. EN=01, UP_DWN=10 for 60ns -> ch0 counts down/saturates at 0 while ch1 holds.
//     Then EN=11 -> ch1 resumes from its held value.

Source files
------------

// File: rtl/multi_updown_counter.sv
// Bank of NUM_CH independent unsigned up/down counters with per-channel clear, load,
// saturate-or-wrap mode, boundary flags and a registered one-cycle wrap pulse.
module multi_updown_counter #(
  parameter int          NUM_CH  = 4,
  parameter int          WIDTH   = 16,
  parameter int unsigned MAX_VAL = (2**WIDTH)-1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH-1:0]       i_up_dwn,
  input  logic [NUM_CH-1:0]       i_sat_mode,
  input  logic [NUM_CH-1:0]       i_clr,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic [NUM_CH*WIDTH-1:0] i_load_val,
  output logic [NUM_CH*WIDTH-1:0] o_count,
  output logic [NUM_CH-1:0]       o_at_max,
  output logic [NUM_CH-1:0]       o_at_min,
  output logic [NUM_CH-1:0]       o_wrap
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_load_slice;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_slice   = i_load_val[g*WIDTH +: WIDTH];
    // Loads above the limit clamp so the count can never leave [0, MAX_VAL].
    assign w_load_clamped = (w_load_slice > LP_MAX) ? LP_MAX : w_load_slice;

    // NOTE: defaults first keep this block latch-free; only the wrap branches raise the pulse.
    always_comb begin
      w_count_next = r_count;
      w_wrap_next  = 1'b0;
      if (i_clr[g]) begin
        w_count_next = '0;
      end else if (i_load[g]) begin
        w_count_next = w_load_clamped;
      end else if (i_en[g]) begin
        if (i_up_dwn[g]) begin
          if (r_count < LP_MAX) begin
            w_count_next = r_count + LP_ONE;
          end else if (!i_sat_mode[g]) begin
            w_count_next = '0;
            w_wrap_next  = 1'b1;
          end
        end else begin
          if (r_count != '0) begin
            w_count_next = r_count - LP_ONE;
          end else if (!i_sat_mode[g]) begin
            w_count_next = LP_MAX;
            w_wrap_next  = 1'b1;
          end
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_count <= '0;
        r_wrap  <= 1'b0;
      end else begin
        r_count <= w_count_next;
        r_wrap  <= w_wrap_next;
      end
    end

    assign o_count[g*WIDTH +: WIDTH] = r_count;
    assign o_at_max[g]               = (r_count == LP_MAX);
    assign o_at_min[g]               = (r_count == '0);
    assign o_wrap[g]                 = r_wrap;
  end

endmodule

// File: tb/tb_multi_updown_counter.sv
// Directed bench for multi_updown_counter: a full-range instance (MAX_VAL=15) and a
// reduced-limit instance (MAX_VAL=10), both NUM_CH=2, WIDTH=4.
module tb_multi_updown_counter;

  logic       clk;
  logic       rst;
  logic [1:0] en, up_dwn, sat_mode, clr, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic [1:0] at_max, at_min, wrap;

  logic [1:0] b_en, b_up_dwn, b_sat_mode, b_clr, b_load;
  logic [7:0] b_load_val;
  logic [7:0] b_count;
  logic [1:0] b_at_max, b_at_min, b_wrap;

  int checks   = 0;
  int failures = 0;

  multi_updown_counter #(.NUM_CH(2), .WIDTH(4), .MAX_VAL(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dwn(up_dwn), .i_sat_mode(sat_mode),
    .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .o_count(count), .o_at_max(at_max), .o_at_min(at_min), .o_wrap(wrap)
  );

  multi_updown_counter #(.NUM_CH(2), .WIDTH(4), .MAX_VAL(10)) dut10 (
    .i_clk(clk), .i_rst(rst), .i_en(b_en), .i_up_dwn(b_up_dwn), .i_sat_mode(b_sat_mode),
    .i_clr(b_clr), .i_load(b_load), .i_load_val(b_load_val),
    .o_count(b_count), .o_at_max(b_at_max), .o_at_min(b_at_min), .o_wrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset, then saturating count-up on both channels.
    rst = 1'b1;
    en = 2'b11; up_dwn = 2'b11; sat_mode = 2'b11; clr = 2'b00; load = 2'b00; load_val = 8'h00;
    b_en = 2'b00; b_up_dwn = 2'b00; b_sat_mode = 2'b00; b_clr = 2'b00; b_load = 2'b00;
    b_load_val = 8'h00;
    #2;
    chk("rst_count", 32'(count), 32'h00);
    chk("rst_at_min", 32'(at_min), 32'h3);
    chk("rst_at_max", 32'(at_max), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    #15 rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t1_count0_e%0d", k), 32'(count[3:0]), (k < 15) ? k : 15);
      chk($sformatf("t1_count1_e%0d", k), 32'(count[7:4]), (k < 15) ? k : 15);
      chk($sformatf("t1_at_max_e%0d", k), 32'(at_max), (k >= 15) ? 32'h3 : 32'h0);
      chk($sformatf("t1_wrap_e%0d", k), 32'(wrap), 32'h0);
    end

    // 2: ch0 wrap mode up through 15 -> 0, then down through 0 -> 15; ch1 held.
    en = 2'b00; sat_mode = 2'b10; load = 2'b01; load_val = 8'h0E;
    step();
    chk("t2_load14", 32'(count[3:0]), 32'd14);
    load = 2'b00; en = 2'b01; up_dwn = 2'b11;
    step();
    chk("t2_up_15", 32'(count[3:0]), 32'd15);
    chk("t2_up_15_wrap", 32'(wrap), 32'h0);
    step();
    chk("t2_up_wrap0", 32'(count[3:0]), 32'd0);
    chk("t2_up_wrap0_pulse", 32'(wrap), 32'h1);
    chk("t2_up_wrap0_at_min", 32'(at_min), 32'h1);
    step();
    chk("t2_up_1", 32'(count[3:0]), 32'd1);
    chk("t2_up_1_wrap", 32'(wrap), 32'h0);
    chk("t2_ch1_held", 32'(count[7:4]), 32'd15);
    up_dwn = 2'b10;
    step();
    chk("t2_dn_0", 32'(count[3:0]), 32'd0);
    chk("t2_dn_0_wrap", 32'(wrap), 32'h0);
    step();
    chk("t2_dn_wrap15", 32'(count[3:0]), 32'd15);
    chk("t2_dn_wrap15_pulse", 32'(wrap), 32'h1);
    chk("t2_dn_wrap15_at_max", 32'(at_max), 32'h3);
    step();
    chk("t2_dn_14", 32'(count[3:0]), 32'd14);
    chk("t2_dn_14_wrap", 32'(wrap), 32'h0);

    // 3: ch1 clear beats load, then load beats count.
    en = 2'b10; up_dwn = 2'b11; clr = 2'b10; load = 2'b10; load_val = 8'h90;
    step();
    chk("t3_clr_beats_load", 32'(count[7:4]), 32'd0);
    chk("t3_ch0_held", 32'(count[3:0]), 32'd14);
    clr = 2'b00;
    step();
    chk("t3_load_beats_en", 32'(count[7:4]), 32'd9);
    load = 2'b00; en = 2'b00;

    // 4: MAX_VAL=10 instance: clamped load, wrap at 10, saturation at 10.
    b_load = 2'b11; b_load_val = 8'hFD;
    step();
    chk("t4_clamp_ch0", 32'(b_count[3:0]), 32'd10);
    chk("t4_clamp_ch1", 32'(b_count[7:4]), 32'd10);
    chk("t4_at_max", 32'(b_at_max), 32'h3);
    b_load = 2'b00; b_en = 2'b11; b_up_dwn = 2'b11; b_sat_mode = 2'b10;
    step();
    chk("t4_wrap_count0", 32'(b_count[3:0]), 32'd0);
    chk("t4_wrap_pulse", 32'(b_wrap), 32'h1);
    chk("t4_sat_hold_ch1", 32'(b_count[7:4]), 32'd10);
    step();
    chk("t4_after_wrap", 32'(b_count[3:0]), 32'd1);
    chk("t4_after_wrap_pulse", 32'(b_wrap), 32'h0);
    b_up_dwn = 2'b00; b_en = 2'b01;
    step();
    step();
    chk("t4_dn_wrap_to_max", 32'(b_count[3:0]), 32'd10);
    chk("t4_dn_wrap_pulse", 32'(b_wrap), 32'h1);
    b_en = 2'b00;

    // 5: asynchronous reset in the middle of a cycle.
    load = 2'b01; load_val = 8'h07;
    step();
    chk("t5_load7", 32'(count[3:0]), 32'd7);
    load = 2'b00; en = 2'b01; up_dwn = 2'b11; sat_mode = 2'b11;
    #3 rst = 1'b1;
    #1;
    chk("t5_async_rst_count", 32'(count), 32'h00);
    chk("t5_async_rst_at_min", 32'(at_min), 32'h3);
    chk("t5_async_rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
    step();
    chk("t5_resume", 32'(count[3:0]), 32'd1);
    chk("t5_ch1_idle", 32'(count[7:4]), 32'd0);

    // 6: ch0 counts down and saturates while ch1 holds, then ch1 resumes.
    en = 2'b00; load = 2'b10; load_val = 8'h50;
    step();
    chk("t6_ch1_load5", 32'(count[7:4]), 32'd5);
    load = 2'b00; en = 2'b01; up_dwn = 2'b10; sat_mode = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t6_ch0_sat_e%0d", k), 32'(count[3:0]), 32'd0);
      chk($sformatf("t6_ch1_hold_e%0d", k), 32'(count[7:4]), 32'd5);
      chk($sformatf("t6_wrap_e%0d", k), 32'(wrap), 32'h0);
    end
    en = 2'b11;
    step();
    chk("t6_ch1_resume6", 32'(count[7:4]), 32'd6);
    chk("t6_ch0_still0", 32'(count[3:0]), 32'd0);
    step();
    chk("t6_ch1_resume7", 32'(count[7:4]), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
